// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 256K x 8 SRAM between the VGA read
// port and the pattern-recorder write port. One access at a time, sequenced
// by a timed FSM that owns cs/oe/we and the tristate data bus.
module sram_arbiter #(
    parameter int RD_CYCLES     = 2,
    parameter int WE_CYCLES     = 2,
    parameter int MAX_RD_STREAK = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [17:0] rd_addr,
    output logic        rd_ack,
    output logic [7:0]  rd_data,
    input  logic        wr_req,
    input  logic [17:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic [17:0] sram_addr,
    inout  wire  [7:0]  sram_io,
    output logic        sram_cs,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        busy
);

    localparam int CNT_MAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int SW      = $clog2(MAX_RD_STREAK + 1);

    localparam logic [CW-1:0] RD_LAST    = CW'(RD_CYCLES - 1);
    localparam logic [CW-1:0] WE_LAST    = CW'(WE_CYCLES - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic [7:0]    wr_data_q;
    logic          io_drive;

    // A read wins unless the write has already waited out a full read streak.
    logic rd_win;
    assign rd_win = rd_req && !(wr_req && (streak == STREAK_MAX));

    // Bus is driven only from registered state, so no glitches on the pins.
    assign sram_io = io_drive ? wr_data_q : {8{1'bz}};

    // Access sequencer: arbitration, pin timing, acks and the streak counter.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            streak    <= '0;
            wr_data_q <= '0;
            io_drive  <= 1'b0;
            sram_addr <= '0;
            sram_cs   <= 1'b1;
            sram_oe   <= 1'b1;
            sram_we   <= 1'b1;
            rd_data   <= '0;
            rd_ack    <= 1'b0;
            wr_ack    <= 1'b0;
        end else begin
            rd_ack <= 1'b0;
            wr_ack <= 1'b0;
            // Streak only means something while a write is waiting.
            if (!wr_req)
                streak <= '0;

            case (state)
                IDLE: begin
                    if (rd_win) begin
                        state     <= READ;
                        busy      <= 1'b1;
                        sram_addr <= rd_addr;
                        sram_cs   <= 1'b0;
                        sram_oe   <= 1'b0;
                        cnt       <= '0;
                        // rd_win with wr_req pending implies streak < max,
                        // so this increment saturates naturally.
                        if (wr_req)
                            streak <= streak + 1'b1;
                    end else if (wr_req) begin
                        state     <= WR_SETUP;
                        busy      <= 1'b1;
                        sram_addr <= wr_addr;
                        wr_data_q <= wr_data;
                        sram_cs   <= 1'b0;
                        streak    <= '0;
                    end
                end

                READ: begin
                    if (cnt == RD_LAST) begin
                        rd_data <= sram_io;
                        rd_ack  <= 1'b1;
                        sram_oe <= 1'b1;
                        sram_cs <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Turnaround cycle: oe high, bus still released.
                WR_SETUP: begin
                    state    <= WR_PULSE;
                    sram_we  <= 1'b0;
                    io_drive <= 1'b1;
                    cnt      <= '0;
                end

                WR_PULSE: begin
                    if (cnt == WE_LAST) begin
                        sram_we <= 1'b1;
                        state   <= WR_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Data stays on the bus one cycle past the we rising edge.
                WR_HOLD: begin
                    io_drive <= 1'b0;
                    sram_cs  <= 1'b1;
                    wr_ack   <= 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    io_drive <= 1'b0;
                    sram_cs  <= 1'b1;
                    sram_oe  <= 1'b1;
                    sram_we  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed protocol checks plus randomized traffic against
// a transaction-level scoreboard and an asynchronous SRAM model.
module tb_sram_arbiter;

    localparam int RD_CYCLES     = 2;
    localparam int WE_CYCLES     = 2;
    localparam int MAX_RD_STREAK = 4;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        rd_req = 1'b0;
    logic [17:0] rd_addr = '0;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        wr_req = 1'b0;
    logic [17:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic [17:0] sram_addr;
    wire  [7:0]  sram_io;
    logic        sram_cs, sram_oe, sram_we, busy;

    sram_arbiter #(
        .RD_CYCLES(RD_CYCLES), .WE_CYCLES(WE_CYCLES), .MAX_RD_STREAK(MAX_RD_STREAK)
    ) dut (
        .clk_in(clk_in), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .sram_addr(sram_addr), .sram_io(sram_io), .sram_cs(sram_cs),
        .sram_oe(sram_oe), .sram_we(sram_we), .busy(busy)
    );

    always #10 clk_in = ~clk_in;

    // Asynchronous SRAM: drives when selected and output-enabled, stores
    // whatever is on the bus while we is low.
    logic [7:0] mem     [0:262143];
    logic [7:0] ref_mem [0:262143];
    assign sram_io = (!sram_cs && !sram_oe && sram_we) ? mem[sram_addr] : 8'hzz;
    always @(negedge clk_in) if (!sram_cs && !sram_we) mem[sram_addr] = sram_io;

    typedef struct {
        logic [17:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [17:0] rd_q[$];
    wr_t         wr_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: bus safety every cycle, scoreboard pops on every ack.
    initial begin : monitor
        logic [17:0] a;
        wr_t         w;
        logic        prev_oe_low;
        int          rd_in_wr;
        prev_oe_low = 1'b0;
        rd_in_wr    = 0;
        forever begin
            @(negedge clk_in);
            check("oe_we_overlap", (!sram_oe && !sram_we) ? 1 : 0, 0);
            check("io_driven_with_oe", (!sram_oe && dut.io_drive) ? 1 : 0, 0);
            check("turnaround_gap", (prev_oe_low && dut.io_drive) ? 1 : 0, 0);
            prev_oe_low = !sram_oe;
            if (rd_ack) begin
                if (rd_q.size() == 0) check("rd_ack_unexpected", 1, 0);
                else begin
                    a = rd_q.pop_front();
                    check("rd_data", rd_data, ref_mem[a]);
                end
            end
            if (wr_ack) begin
                if (wr_q.size() == 0) check("wr_ack_unexpected", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    check("wr_mem", mem[w.addr], w.data);
                    ref_mem[w.addr] = w.data;
                end
                check("wr_starved", (rd_in_wr <= MAX_RD_STREAK + 1) ? 1 : 0, 1);
                rd_in_wr = 0;
            end else if (!wr_req) rd_in_wr = 0;
            else if (rd_ack) rd_in_wr++;
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int ack_n, oe_cnt, we_low, bad, busy_seen, seg0, seg1, wacks, got, gotw, final_rd;
        logic [17:0] a;
        wr_t w;
        logic we_l [0:31];
        logic drv_l [0:31];
        logic cs_l [0:31];
        logic [7:0] io_l [0:31];
        logic [17:0] ad_l [0:31];

        // ---- reset state
        reset = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_cs", sram_cs, 1);
        check("rst_oe", sram_oe, 1);
        check("rst_we", sram_we, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_acks", {rd_ack, wr_ack}, 0);
        check("rst_busy", busy, 0);
        check("rst_io_z", dut.io_drive, 0);

        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'(i * 37 + 11);
            ref_mem[i] = mem[i];
        end
        mem[18'h00123] = 8'hA5; ref_mem[18'h00123] = 8'hA5;
        mem[18'h3FFFE] = 8'h00; ref_mem[18'h3FFFE] = 8'h00;
        reset = 1'b1;
        @(negedge clk_in);

        // ---- single read
        rd_addr = 18'h00123; rd_req = 1'b1; rd_q.push_back(18'h00123);
        ack_n = 0; oe_cnt = 0; we_low = 0; bad = 0; busy_seen = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_in);
            if (!sram_oe) begin
                oe_cnt++;
                if (sram_addr !== 18'h00123) bad++;
            end
            if (!sram_we) we_low++;
            if (n == 1) busy_seen = busy;
            if (rd_ack) begin ack_n = n; rd_req = 1'b0; break; end
        end
        check("rd_latency", ack_n, RD_CYCLES + 1);
        check("rd_oe_cycles", oe_cnt, RD_CYCLES);
        check("rd_addr_pin", bad, 0);
        check("rd_we_stays_high", we_low, 0);
        check("rd_busy", busy_seen, 1);
        @(negedge clk_in);
        check("rd_ack_one_cycle", rd_ack, 0);
        check("rd_data_held", rd_data, 8'hA5);

        // ---- single write at top of address space
        wr_addr = 18'h3FFFE; wr_data = 8'h5A; wr_req = 1'b1;
        wr_q.push_back('{18'h3FFFE, 8'h5A});
        ack_n = 0;
        for (int n = 0; n < 32; n++) begin
            we_l[n] = 1'b1; drv_l[n] = 1'b0; cs_l[n] = 1'b1; io_l[n] = '0; ad_l[n] = '0;
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_in);
            we_l[n] = sram_we; drv_l[n] = dut.io_drive; cs_l[n] = sram_cs;
            io_l[n] = sram_io; ad_l[n] = sram_addr;
            if (wr_ack) begin ack_n = n; wr_req = 1'b0; break; end
        end
        check("wr_latency", ack_n, WE_CYCLES + 3);
        check("wr_setup_cs", cs_l[1], 0);
        check("wr_setup_we", we_l[1], 1);
        check("wr_setup_io_z", drv_l[1], 0);
        check("wr_setup_addr", ad_l[1], 18'h3FFFE);
        bad = 0;
        for (int n = 2; n <= WE_CYCLES + 1; n++)
            if (we_l[n] !== 1'b0 || drv_l[n] !== 1'b1 || io_l[n] !== 8'h5A ||
                ad_l[n] !== 18'h3FFFE) bad++;
        check("wr_pulse", bad, 0);
        check("wr_hold_we", we_l[WE_CYCLES + 2], 1);
        check("wr_hold_io", drv_l[WE_CYCLES + 2], 1);
        check("wr_hold_data", io_l[WE_CYCLES + 2], 8'h5A);
        check("wr_release_io", drv_l[ack_n], 0);
        check("wr_release_cs", cs_l[ack_n], 1);
        // read it back through the arbiter
        rd_addr = 18'h3FFFE; rd_req = 1'b1; rd_q.push_back(18'h3FFFE);
        got = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_in);
            if (rd_ack) begin got = 1; rd_req = 1'b0; break; end
        end
        check("wr_readback_ack", got, 1);
        check("wr_readback_data", rd_data, 8'h5A);
        @(negedge clk_in);

        // ---- simultaneous requests: read first, write in idle-return cycle
        rd_addr = 18'd5; rd_req = 1'b1; rd_q.push_back(18'd5);
        wr_addr = 18'd6; wr_data = 8'hC3; wr_req = 1'b1; wr_q.push_back('{18'd6, 8'hC3});
        got = 0; gotw = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk_in);
            if (rd_ack) begin got = n; rd_req = 1'b0; end
            if (wr_ack) begin gotw = n; wr_req = 1'b0; break; end
        end
        check("simul_rd_first", got, RD_CYCLES + 1);
        check("simul_wr_after", gotw, RD_CYCLES + 1 + 1 + WE_CYCLES + 2);
        @(negedge clk_in);

        // ---- starvation: continuous reads, two back-to-back writes
        a = 18'($urandom_range(0, 63));
        rd_addr = a; rd_req = 1'b1; rd_q.push_back(a);
        wr_addr = 18'h30; wr_data = 8'($urandom); wr_req = 1'b1;
        wr_q.push_back('{18'h30, wr_data});
        seg0 = 0; seg1 = 0; wacks = 0; final_rd = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_in);
            if (rd_ack) begin
                if (wacks == 2) begin final_rd = 1; rd_req = 1'b0; break; end
                if (wacks == 0) seg0++; else seg1++;
                a = 18'($urandom_range(0, 63));
                rd_addr = a; rd_q.push_back(a);
            end
            if (wr_ack) begin
                wacks++;
                if (wacks == 1) begin
                    wr_addr = 18'h31; wr_data = 8'($urandom);
                    wr_q.push_back('{18'h31, wr_data});
                end else wr_req = 1'b0;
            end
        end
        check("streak_reads_before_wr", seg0, MAX_RD_STREAK);
        check("streak_reads_after_wr", seg1, MAX_RD_STREAK);
        check("streak_wr_acks", wacks, 2);
        check("streak_reads_resume", final_rd, 1);
        @(negedge clk_in);

        // ---- reset during the second write-pulse cycle
        wr_addr = 18'h20000; wr_data = 8'h3C; wr_req = 1'b1;
        wr_q.push_back('{18'h20000, 8'h3C});
        repeat (3) @(negedge clk_in);
        check("abort_in_pulse", sram_we, 0);
        reset = 1'b0; wr_req = 1'b0;
        w = wr_q.pop_back();
        rd_addr = 18'h11; rd_req = 1'b1; rd_q.push_back(18'h11);
        @(negedge clk_in);
        check("abort_we", sram_we, 1);
        check("abort_cs", sram_cs, 1);
        check("abort_oe", sram_oe, 1);
        check("abort_io_z", dut.io_drive, 0);
        check("abort_no_ack", wr_ack, 0);
        check("abort_busy", busy, 0);
        reset = 1'b1;
        got = 0; gotw = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_in);
            if (wr_ack) gotw = 1;
            if (rd_ack) begin got = n; rd_req = 1'b0; break; end
        end
        check("post_reset_rd_latency", got, RD_CYCLES + 1);
        check("abort_no_late_ack", gotw, 0);

        // ---- random traffic
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk_in); #1;
            if (rd_req && rd_ack) rd_req = 1'b0;
            if (wr_req && wr_ack) wr_req = 1'b0;
            if (!rd_req && $urandom_range(0, 2) != 0) begin
                a = 18'($urandom_range(0, 63));
                rd_addr = a; rd_req = 1'b1; rd_q.push_back(a);
            end
            if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_addr = 18'($urandom_range(0, 63)); wr_data = 8'($urandom);
                wr_req = 1'b1; wr_q.push_back('{wr_addr, wr_data});
            end
        end
        for (int c = 0; c < 300 && (rd_req || wr_req); c++) begin
            @(posedge clk_in); #1;
            if (rd_req && rd_ack) rd_req = 1'b0;
            if (wr_req && wr_ack) wr_req = 1'b0;
        end
        check("drain_done", (rd_req || wr_req) ? 1 : 0, 0);
        repeat (2) @(negedge clk_in);
        check("rd_q_empty", rd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 256K x 8 asynchronous SRAM between two requesters: the VGA display reader (read port) and the pattern recorder (write port).
- Sequences every SRAM access with a timed state machine and owns cs/oe/we and the tristate io bus.
- Guarantees a dead bus cycle between read and write.
- Read has priority; a streak limit prevents write starvation. Sits between the vga_sync-driven pixel logic and the SRAM pins, in the 50 MHz clock domain.

Parameters:
- RD_CYCLES, 2, clocks oe held low per read; data sampled on the last one (min 1)
- WE_CYCLES, 2, clocks we held low per write (min 1)
- MAX_RD_STREAK, 4, consecutive read grants allowed while wr_req is pending (min 1)

Ports:
- clk_in  input  1  system clock (50 MHz, clk_div[0] domain)
- reset  input  1  synchronous, active-low reset
- rd_req  input  1  read request, level, held until rd_ack
- rd_addr  input  18  read address, stable while rd_req high
- rd_ack  output  1  one-cycle pulse: rd_data valid
- rd_data  output  8  read data, held until next rd_ack
- wr_req  input  1  write request, level, held until wr_ack
- wr_addr  input  18  write address, stable while wr_req high
- wr_data  input  8  write data, stable while wr_req high
- wr_ack  output  1  one-cycle pulse: write complete
- sram_addr  output  18  SRAM address
- sram_io  inout  8  SRAM data bus
- sram_cs  output  1  chip select, active low
- sram_oe  output  1  output enable, active low
- sram_we  output  1  write enable, active low
- busy  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. Control updates only on posedge clk_in.
- Reset (reset==0 at a clock edge) applies, taking effect at that edge:
  - state=IDLE, sram_cs=1, sram_oe=1, sram_we=1, io released (Z)
  - sram_addr=0, rd_data=0, rd_ack=0, wr_ack=0, streak=0
- Reset mid-access aborts immediately: no ack for the aborted request; we/oe are high after that edge.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
- Arbitration in IDLE:
  - rd_req and not (wr_req and streak==MAX_RD_STREAK) -> READ
  - else wr_req -> WR_SETUP
  - else stay in IDLE
- Streak counter:
  - increments on each read grant while wr_req=1
  - clears on a write grant, or on any edge with wr_req=0
  - saturates at MAX_RD_STREAK
- READ:
  - on entry: sram_addr<=rd_addr, sram_cs<=0, sram_oe<=0, cnt<=0
  - cnt increments each cycle
  - when cnt==RD_CYCLES-1: rd_data<=sram_io, rd_ack<=1, sram_oe<=1, sram_cs<=1, -> IDLE
  - rd_ack rises RD_CYCLES clocks after the grant edge
- WR_SETUP (1 cycle):
  - sram_addr<=wr_addr, sram_cs<=0, oe=1, io still Z (turnaround cycle)
  - -> WR_PULSE
- WR_PULSE (WE_CYCLES cycles):
  - io driven with a registered copy of wr_data, sram_we=0
  - address and data constant throughout
  - -> WR_HOLD
- WR_HOLD (1 cycle):
  - sram_we=1, io still driven (data hold)
  - at exit: io released, sram_cs<=1, wr_ack<=1, -> IDLE
  - write latency: grant edge to wr_ack = WE_CYCLES+2 clocks
- io is driven only in WR_PULSE and WR_HOLD. sram_oe and sram_we are never low in the same cycle.
- Ack pulses last exactly one cycle. The requester must drop or renew its req in the ack cycle.
  - The arbiter returns to IDLE for one cycle after every access; a req still high in that cycle is treated as a new request.
- Max read throughput: one byte per RD_CYCLES+1 clocks.
- Addresses pass through unmodified; no wrap or increment logic (address generation stays in the requesters).
- A change to rd_addr or wr_addr while its req is pending but not yet granted is legal; the value at the grant edge is used.

Test Plan:
- Single read: RD_CYCLES=2, SRAM model holds 0xA5 at 0x00123; pulse rd_req -> sram_oe low exactly 2 cycles with sram_addr=0x00123, rd_ack 1 cycle, rd_data=0xA5, we stays 1.
- Single write: wr_addr=0x3FFFE, wr_data=0x5A, WE_CYCLES=2 -> 1 setup cycle with io=Z, we low 2 cycles with io=0x5A, 1 hold cycle, wr_ack at grant+4; model reads back 0x5A.
- Simultaneous req (rd and wr both high from idle, streak 0) -> read granted first; write granted in the idle-return cycle only if rd_req is low; else after 4 reads (MAX_RD_STREAK=4).
- Starvation: rd_req held high continuously, wr_req high -> exactly 4 rd_acks, then 1 wr_ack, then reads resume; streak=0 after the write.
- Bus safety: random rd/wr traffic for 10k cycles -> assert never (oe==0 and we==0), io never driven while oe==0, at least one Z cycle between oe rising and io being driven.
- Reset mid-write: assert reset=0 during second WR_PULSE cycle -> next edge we=1, cs=1, io Z, no wr_ack; after release, a pending rd_req is serviced normally.
